// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-requester round-robin grant; ptr=0 favours requester 0 on contention.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant[0] = valid0 & (~valid1 | ~ptr);
    grant[1] = valid1 & (~valid0 |  ptr);
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write port shared by two requesters, with a full zero-clear
// sequence that runs after reset and on demand.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned AW           = AW_DEF,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic          write,
  output logic [AW-1:0] dr,
  output logic [DW-1:0] wrData
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          ptr;
  logic [1:0]    grant;
  logic          run_ok;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr),
    .grant  (grant)
  );

  // Grants are suppressed while reset is held, even when reset parks us in RUN.
  always_comb begin
    run_ok     = reset & (state == ST_RUN) & ~clr_start;
    req0_ready = run_ok & grant[0];
    req1_ready = run_ok & grant[1];
    busy       = (state == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      if (CLR_ON_RESET) state <= ST_CLEAR;
      cnt      <= '0;
      ptr      <= 1'b0;
      write    <= 1'b0;
      dr       <= '0;
      wrData   <= '0;
      clr_done <= 1'b0;
    end else begin
      write    <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          write  <= 1'b1;
          dr     <= cnt;
          wrData <= '0;
          if (cnt == '1) begin
            cnt      <= '0;
            state    <= ST_RUN;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_RUN: begin
          if (clr_start) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (req0_ready) begin
            write  <= 1'b1;
            dr     <= req0_addr;
            wrData <= req0_data;
            ptr    <= 1'b1;
          end else if (req1_ready) begin
            write  <= 1'b1;
            dr     <= req1_addr;
            wrData <= req1_data;
            ptr    <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequences, arbitration, reset abort.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        clr_start;
  logic        busy;
  logic        clr_done;
  logic        write;
  logic [4:0]  dr;
  logic [31:0] wrData;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  regfile_wr_arbiter #(
    .DW           (32),
    .AW           (5),
    .CLR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .busy       (busy),
    .clr_done   (clr_done),
    .write      (write),
    .dr         (dr),
    .wrData     (wrData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps through a full 32-write clear; optionally pulses clr_start when cnt==pulse_at.
  task automatic clear_seq(input string tag, input int unsigned pulse_at);
    int unsigned nwr = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      tick();
      if (write) nwr++;
      chk({tag, "_dr"},     32'(dr),       k);
      chk({tag, "_data"},   wrData,        32'h0);
      chk({tag, "_busy"},   32'(busy),     32'((k < 31) ? 1 : 0));
      chk({tag, "_done"},   32'(clr_done), 32'((k == 31) ? 1 : 0));
      clr_start = (pulse_at != 0) && (k + 1 == pulse_at);
      #1;
      chk({tag, "_rdy0"}, 32'(req0_ready), 32'h0);
      chk({tag, "_rdy1"}, 32'(req1_ready), (k == 31) ? 32'(req1_valid) : 32'h0);
    end
    clr_start = 1'b0;
    chk({tag, "_nwr"}, nwr, 32);
  endtask

  initial begin
    reset = 1'b0; clr_start = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
    #2;
    chk("rst_write", 32'(write),      32'h0);
    chk("rst_dr",    32'(dr),         32'h0);
    chk("rst_data",  wrData,          32'h0);
    chk("rst_done",  32'(clr_done),   32'h0);
    chk("rst_busy",  32'(busy),       32'h1);
    chk("rst_rdy0",  32'(req0_ready), 32'h0);
    tick(); tick();
    chk("rst_write2", 32'(write), 32'h0);
    req0_valid = 1'b0;
    reset = 1'b1;

    clear_seq("por", 0);
    tick();
    chk("por_after_write", 32'(write),    32'h0);
    chk("por_after_done",  32'(clr_done), 32'h0);
    chk("por_after_dr",    32'(dr),       32'd31);

    // Both requesters held: alternate 1,2,1,2 starting with requester 0.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_rdy0", 32'(req0_ready), 32'((i % 2 == 0) ? 1 : 0));
      chk("alt_rdy1", 32'(req1_ready), 32'((i % 2 == 1) ? 1 : 0));
      tick();
      chk("alt_write", 32'(write), 32'h1);
      chk("alt_dr",    32'(dr),    (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_data",  wrData,     (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Lone requester 1 wins while the pointer favours requester 0; address 0 passes.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hA5A5A5A5;
    #1;
    chk("solo1_rdy0", 32'(req0_ready), 32'h0);
    chk("solo1_rdy1", 32'(req1_ready), 32'h1);
    tick();
    chk("solo1_write", 32'(write), 32'h1);
    chk("solo1_dr",    32'(dr),    32'd0);
    chk("solo1_data",  wrData,     32'hA5A5A5A5);
    req1_valid = 1'b0;

    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("solo0_rdy0", 32'(req0_ready), 32'h1);
    chk("solo0_rdy1", 32'(req1_ready), 32'h0);
    tick();
    chk("solo0_write", 32'(write), 32'h1);
    chk("solo0_dr",    32'(dr),    32'd5);
    chk("solo0_data",  wrData,     32'hDEADBEEF);
    req0_valid = 1'b0;
    tick();
    chk("idle_write", 32'(write), 32'h0);
    chk("idle_dr",    32'(dr),    32'd5);
    chk("idle_data",  wrData,     32'hDEADBEEF);

    // Pointer now favours requester 1.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("ptr1_rdy0", 32'(req0_ready), 32'h0);
    chk("ptr1_rdy1", 32'(req1_ready), 32'h1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // clr_start beats a pending request; a mid-clear clr_start is ignored.
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    clr_start = 1'b1;
    #1;
    chk("cs_rdy0", 32'(req0_ready), 32'h0);
    chk("cs_rdy1", 32'(req1_ready), 32'h0);
    tick();
    clr_start = 1'b0;
    chk("cs_write", 32'(write), 32'h0);
    chk("cs_busy",  32'(busy),  32'h1);
    chk("cs_dr",    32'(dr),    32'd5);
    clear_seq("clrq", 20);
    tick();
    chk("post_clr_write", 32'(write), 32'h1);
    chk("post_clr_dr",    32'(dr),    32'd7);
    chk("post_clr_data",  wrData,     32'h77);
    req1_valid = 1'b0;

    // Reset lands at cnt==10, held two cycles, then a fresh full clear.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("rc_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 10; k++) tick();
    chk("rc_dr9", 32'(dr), 32'd9);
    reset = 1'b0;
    #1;
    chk("rc_write", 32'(write),    32'h0);
    chk("rc_dr",    32'(dr),       32'h0);
    chk("rc_data",  wrData,        32'h0);
    chk("rc_busy2", 32'(busy),     32'h1);
    chk("rc_done",  32'(clr_done), 32'h0);
    tick();
    chk("rc_hold_write", 32'(write), 32'h0);
    tick();
    reset = 1'b1;
    clear_seq("rst_clr", 0);
    tick();
    chk("rst_clr_after", 32'(write), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
